wb_stage: RTL and testbench

- Final (write-back) stage of the 5-stage MIPS pipeline. It is the other end of the decode stage's register-file write port.
- Holds the MEM/WB pipeline register and selects the write-back value: ALU result, extended load data, or link address.
- Drives the rw/din/we triple consumed by the decode stage's register file.
- Executes syscall side effects (halt, print integer) and counts retired instructions.

---
 rtl/wb_stage.sv | 166 ++++++++++++++++
 tb/tb_wb_stage.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB pipeline register, write-back mux with load extension,
// syscall side effects (halt / print) and a saturating retired-instruction counter.
module wb_stage #(
    parameter int REGWRITE_BIT = 2,
    parameter int MEMTOREG_BIT = 3,
    parameter int JAL_BIT      = 13,
    parameter int SYSCALL_BIT  = 14,
    parameter int HALT_CODE    = 10,
    parameter int PRINT_CODE   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_ir,
    input  logic [31:0] in_signal,
    input  logic [4:0]  in_dst,
    input  logic [31:0] in_alu,
    input  logic [31:0] in_mem,
    input  logic [31:0] in_v0,
    input  logic [31:0] in_a0,
    output logic [4:0]  rw,
    output logic [31:0] din,
    output logic        we,
    output logic        halted,
    output logic        show_en,
    output logic [31:0] show_data,
    output logic [31:0] retired
);

    localparam int          DATA_W = 32;
    localparam logic [5:0]  OP_LB  = 6'h20;
    localparam logic [5:0]  OP_LH  = 6'h21;
    localparam logic [5:0]  OP_LW  = 6'h23;
    localparam logic [5:0]  OP_LBU = 6'h24;
    localparam logic [5:0]  OP_LHU = 6'h25;

    // Pick the addressed lane out of the aligned word and extend it to 32 bits.
    function automatic logic [DATA_W-1:0] load_ext(input logic [5:0]        op,
                                                   input logic [1:0]        lane,
                                                   input logic [DATA_W-1:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [DATA_W-1:0] r;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (op)
            OP_LB:   r = {{24{b[7]}}, b};
            OP_LBU:  r = {24'd0, b};
            OP_LH:   r = {{16{h[15]}}, h};
            OP_LHU:  r = {16'd0, h};
            OP_LW:   r = word;
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    logic              vld_p1;
    logic [DATA_W-1:0] pc_p1;
    logic [DATA_W-1:0] ir_p1;
    logic [DATA_W-1:0] sig_p1;
    logic [4:0]        dst_p1;
    logic [DATA_W-1:0] alu_p1;
    logic [DATA_W-1:0] mem_p1;
    logic [DATA_W-1:0] v0_p1;
    logic [DATA_W-1:0] a0_p1;
    logic              done_p1;

    logic              halted_q;
    logic              show_en_q;
    logic [DATA_W-1:0] show_data_q;
    logic [DATA_W-1:0] retired_cnt;

    logic              act;
    logic              sys_act;
    logic [DATA_W-1:0] link_addr;
    logic [DATA_W-1:0] load_val;

    // ---- MEM/WB register ----
    // done_p1 marks an entry whose one-time effects (count, syscall) already fired,
    // so a stalled entry is only acted on at its first edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            pc_p1   <= '0;
            ir_p1   <= '0;
            sig_p1  <= '0;
            dst_p1  <= '0;
            alu_p1  <= '0;
            mem_p1  <= '0;
            v0_p1   <= '0;
            a0_p1   <= '0;
            done_p1 <= 1'b0;
        end else if (flush) begin
            vld_p1  <= 1'b0;
            done_p1 <= 1'b0;
        end else if (!stall) begin
            vld_p1  <= in_valid;
            pc_p1   <= in_pc;
            ir_p1   <= in_ir;
            sig_p1  <= in_signal;
            dst_p1  <= in_dst;
            alu_p1  <= in_alu;
            mem_p1  <= in_mem;
            v0_p1   <= in_v0;
            a0_p1   <= in_a0;
            done_p1 <= 1'b0;
        end else begin
            done_p1 <= 1'b1;
        end
    end

    assign act     = vld_p1 & ~done_p1 & ~halted_q;
    assign sys_act = act & sig_p1[SYSCALL_BIT];

    // ---- write-back select ----
    assign link_addr = pc_p1 + 32'd4;
    assign load_val  = load_ext(ir_p1[31:26], alu_p1[1:0], mem_p1);

    always_comb begin
        din = alu_p1;
        if (sig_p1[JAL_BIT])
            din = link_addr;
        else if (sig_p1[MEMTOREG_BIT])
            din = load_val;
    end

    assign rw = dst_p1;
    assign we = vld_p1 & sig_p1[REGWRITE_BIT] & (dst_p1 != 5'd0) & ~halted_q;

    // ---- syscall effects and retire count ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halted_q    <= 1'b0;
            show_en_q   <= 1'b0;
            show_data_q <= '0;
            retired_cnt <= '0;
        end else begin
            show_en_q <= 1'b0;
            if (sys_act && v0_p1 == DATA_W'(HALT_CODE))
                halted_q <= 1'b1;
            if (sys_act && v0_p1 == DATA_W'(PRINT_CODE)) begin
                show_en_q   <= 1'b1;
                show_data_q <= a0_p1;
            end
            retired_cnt <= act ? sat_inc(retired_cnt) : retired_cnt;
        end
    end

    assign halted    = halted_q;
    assign show_en   = show_en_q;
    assign show_data = show_data_q;
    assign retired   = retired_cnt;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: expected write-back triples are queued at issue
// and popped when the registered instruction appears on rw/din/we.
module tb_wb_stage;

    localparam logic [31:0] S_RW  = 32'h1 << 2;
    localparam logic [31:0] S_M2R = 32'h1 << 3;
    localparam logic [31:0] S_JAL = 32'h1 << 13;
    localparam logic [31:0] S_SYS = 32'h1 << 14;

    logic        clk = 1'b0;
    logic        rst, stall, flush, in_valid;
    logic [31:0] in_pc, in_ir, in_signal, in_alu, in_mem, in_v0, in_a0;
    logic [4:0]  in_dst;
    logic [4:0]  rw;
    logic [31:0] din, show_data, retired;
    logic        we, halted, show_en;

    typedef struct {
        string       tag;
        logic [4:0]  rw;
        logic [31:0] din;
        logic        we;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errs   = 0;
    logic [31:0] exp_ret;
    logic        exp_halted;

    wb_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .in_pc(in_pc), .in_ir(in_ir), .in_signal(in_signal), .in_dst(in_dst),
        .in_alu(in_alu), .in_mem(in_mem), .in_v0(in_v0), .in_a0(in_a0),
        .rw(rw), .din(din), .we(we), .halted(halted), .show_en(show_en),
        .show_data(show_data), .retired(retired)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        stall    = 1'b0;
        flush    = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Drive one instruction at a negedge, check its write-back one edge later.
    task automatic issue(input string tag, input logic [31:0] pc, input logic [31:0] ir,
                         input logic [31:0] sig, input logic [4:0] dst, input logic [31:0] alu,
                         input logic [31:0] mem, input logic [31:0] v0, input logic [31:0] a0,
                         input logic [31:0] exp_din, input logic exp_we);
        exp_t e;
        in_valid = 1'b1; stall = 1'b0; flush = 1'b0;
        in_pc = pc; in_ir = ir; in_signal = sig; in_dst = dst;
        in_alu = alu; in_mem = mem; in_v0 = v0; in_a0 = a0;
        sb.push_back('{tag: tag, rw: dst, din: exp_din, we: exp_we});
        @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        check_eq({e.tag, ".rw"}, 32'(rw), 32'(e.rw));
        check_eq({e.tag, ".din"}, din, e.din);
        check_eq({e.tag, ".we"}, 32'(we), 32'(e.we));
        check_eq({e.tag, ".retired"}, retired, exp_ret);
        if (!exp_halted && exp_ret != 32'hFFFF_FFFF)
            exp_ret = exp_ret + 1;
        if (!exp_halted && sig[14] && v0 == 32'd10)
            exp_halted = 1'b1;
    endtask

    initial begin
        int cnt;
        // Reset with arbitrary inputs: outputs clear before any clock edge.
        rst = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b1;
        in_pc = 32'hDEAD_BEEF; in_ir = 32'h8C00_0000; in_signal = 32'hFFFF_FFFF;
        in_dst = 5'd7; in_alu = 32'h1234_5678; in_mem = 32'hCAFE_F00D;
        in_v0 = 32'd1; in_a0 = 32'd99;
        exp_ret = 32'd0; exp_halted = 1'b0;
        #1;
        check_eq("rst.rw", 32'(rw), 32'd0);
        check_eq("rst.din", din, 32'd0);
        check_eq("rst.we", 32'(we), 32'd0);
        check_eq("rst.halted", 32'(halted), 32'd0);
        check_eq("rst.show_en", 32'(show_en), 32'd0);
        check_eq("rst.show_data", show_data, 32'd0);
        check_eq("rst.retired", retired, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b0;

        issue("addu", 32'h0040_0000, 32'h0000_0021, S_RW, 5'd8, 32'h0000_1234, 32'h0, 32'h0, 32'h0, 32'h0000_1234, 1'b1);
        issue("lb",   32'h0040_0004, {6'h20, 26'd0}, S_RW | S_M2R, 5'd9, 32'h0000_1003, 32'h80FF_7F01, 0, 0, 32'hFFFF_FF80, 1'b1);
        issue("lbu",  32'h0040_0008, {6'h24, 26'd0}, S_RW | S_M2R, 5'd9, 32'h0000_1003, 32'h80FF_7F01, 0, 0, 32'h0000_0080, 1'b1);
        issue("lh",   32'h0040_000C, {6'h21, 26'd0}, S_RW | S_M2R, 5'd10, 32'h0000_1002, 32'h80FF_7F01, 0, 0, 32'hFFFF_80FF, 1'b1);
        issue("lhu",  32'h0040_0010, {6'h25, 26'd0}, S_RW | S_M2R, 5'd10, 32'h0000_1002, 32'h80FF_7F01, 0, 0, 32'h0000_80FF, 1'b1);
        issue("lw",   32'h0040_0014, {6'h23, 26'd0}, S_RW | S_M2R, 5'd11, 32'h0000_1000, 32'h80FF_7F01, 0, 0, 32'h80FF_7F01, 1'b1);
        issue("jal",  32'h0040_0020, {6'h03, 26'd8}, S_RW | S_JAL, 5'd31, 32'h0000_0000, 32'h0, 0, 0, 32'h0040_0024, 1'b1);
        issue("r0",   32'h0040_0024, 32'h0000_0021, S_RW, 5'd0, 32'h0000_0055, 32'h0, 0, 0, 32'h0000_0055, 1'b0);
        idle();
        check_eq("retired.after8", retired, exp_ret);

        // Print syscall held three cycles under stall: strobe once.
        in_valid = 1'b1; stall = 1'b0; flush = 1'b0;
        in_pc = 32'h0040_0028; in_ir = 32'h0000_000C; in_signal = S_SYS; in_dst = 5'd0;
        in_alu = 32'h0; in_mem = 32'h0; in_v0 = 32'd1; in_a0 = 32'd42;
        @(posedge clk);
        @(negedge clk);
        check_eq("print.pre", 32'(show_en), 32'd0);
        stall = 1'b1;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (show_en) cnt++;
        end
        check_eq("print.data", show_data, 32'd42);
        idle();
        check_eq("print.strobes", 32'(cnt), 32'd1);
        check_eq("print.after", 32'(show_en), 32'd0);
        check_eq("print.hold", show_data, 32'd42);
        exp_ret = exp_ret + 1;
        check_eq("print.retired", retired, exp_ret);

        // Halt, then later writes are suppressed and the counter freezes.
        issue("halt",  32'h0040_002C, 32'h0000_000C, S_SYS, 5'd0, 32'h0, 32'h0, 32'd10, 32'd0, 32'h0, 1'b0);
        issue("post1", 32'h0040_0030, 32'h0000_0021, S_RW, 5'd10, 32'h7, 32'h0, 0, 0, 32'h7, 1'b0);
        check_eq("halted", 32'(halted), 32'd1);
        issue("post2", 32'h0040_0034, 32'h0000_0021, S_RW, 5'd12, 32'h9, 32'h0, 32'd1, 32'd5, 32'h9, 1'b0);
        idle();
        check_eq("halt.retired", retired, exp_ret);
        check_eq("halt.no_print", 32'(show_en), 32'd0);

        // Asynchronous reset mid-operation.
        #2 rst = 1'b1;
        #1;
        check_eq("rst2.halted", 32'(halted), 32'd0);
        check_eq("rst2.retired", retired, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_ret = 32'd0; exp_halted = 1'b0;

        // Flush beats stall: bubble captured, nothing written or counted.
        issue("pre_flush", 32'h0040_0100, 32'h0000_0021, S_RW, 5'd3, 32'h77, 32'h0, 0, 0, 32'h77, 1'b1);
        in_valid = 1'b1; flush = 1'b1; stall = 1'b1;
        in_signal = S_RW; in_dst = 5'd5; in_alu = 32'h88;
        @(posedge clk);
        @(negedge clk);
        check_eq("flush.we", 32'(we), 32'd0);
        check_eq("flush.retired", retired, exp_ret);
        idle();
        check_eq("flush.retired2", retired, exp_ret);

        // Counter saturation from a preloaded value.
        force dut.retired_cnt = 32'hFFFF_FFFE;
        @(posedge clk);
        @(negedge clk);
        release dut.retired_cnt;
        exp_ret = 32'hFFFF_FFFE;
        check_eq("sat.preload", retired, exp_ret);
        issue("sat1", 32'h0040_0200, 32'h0000_0021, S_RW, 5'd4, 32'h1, 32'h0, 0, 0, 32'h1, 1'b1);
        issue("sat2", 32'h0040_0204, 32'h0000_0021, S_RW, 5'd4, 32'h2, 32'h0, 0, 0, 32'h2, 1'b1);
        issue("sat3", 32'h0040_0208, 32'h0000_0021, S_RW, 5'd4, 32'h3, 32'h0, 0, 0, 32'h3, 1'b1);
        idle();
        check_eq("sat.final", retired, 32'hFFFF_FFFF);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
